score_keeper: RTL

Sequential bookkeeping stage that sits directly downstream of the combinational scoring stage and closes its feedback loop. On each judged-note strobe it registers the per-note base score, bonus score and combo. It accumulates run totals and tracks health and pass/fail. It feeds `last_combo`, `now_cnt` and `last_base_score` back to the scoring stage, and final results to the display/result stage.

---
 rtl/score_keeper_pkg.sv | 24 ++
 rtl/score_keeper_sat_add.sv | 25 ++
 rtl/score_keeper.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper_pkg
// Purpose  : Shared constants for the score keeper: FSM state encodings,
//            the No Fail mode code and the per-note score width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package score_keeper_pkg;

    // Width of the per-note score, combo and note-count buses.
    localparam int c_SCORE_BITS = 21;

    // FSM state encodings, as seen on the state output.
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_PLAY   = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;
    localparam logic [1:0] c_ST_FAILED = 2'd3;

    // Game mode in which running out of health does not end the song.
    localparam logic [1:0] c_MOD_NOFAIL = 2'b01;

endpackage : score_keeper_pkg
`default_nettype wire

// File: rtl/score_keeper_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Purpose  : Unsigned adder of parameterised width that clamps to all-ones
//            instead of wrapping.
// Ports    : i_a, i_b [W-1:0] - operands
//            o_sum    [W-1:0] - min(i_a + i_b, 2^W - 1)
// Revision : 1.0 - initial release
// ============================================================================
module sat_add #(
    parameter int W = 21
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    // One extra bit catches the carry that signals overflow.
    logic [W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule : sat_add
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Registers per-note results from the scoring stage, accumulates
//            run totals, tracks health and pass/fail, and feeds last_combo,
//            now_cnt and last_base_score back to the scoring stage.
// Ports    : clk, rst                - clock, async active-high reset
//            start, abort            - song control pulses
//            hit_valid               - one judged note is valid this cycle
//            base_score, bonus_score - per-note scores [20:0]
//            combo                   - new combo value [20:0]
//            total_note, mod         - song length / mode, sampled on start
//            last_combo, now_cnt, last_base_score - feedback [20:0]
//            total_score [SCORE_W-1:0], max_combo, miss_count - results
//            health [6:0], state [1:0], done - status
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int SCORE_W  = 24,
    parameter int HP_START = 100,
    parameter int HP_MAX   = 100,
    parameter int HP_MISS  = 8,
    parameter int HP_GAIN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    hit_valid,
    input  logic [c_SCORE_BITS-1:0] base_score,
    input  logic [c_SCORE_BITS-1:0] bonus_score,
    input  logic [c_SCORE_BITS-1:0] combo,
    input  logic [c_SCORE_BITS-1:0] total_note,
    input  logic [1:0]              mod,
    output logic [c_SCORE_BITS-1:0] last_combo,
    output logic [c_SCORE_BITS-1:0] now_cnt,
    output logic [c_SCORE_BITS-1:0] last_base_score,
    output logic [SCORE_W-1:0]      total_score,
    output logic [c_SCORE_BITS-1:0] max_combo,
    output logic [c_SCORE_BITS-1:0] miss_count,
    output logic [6:0]              health,
    output logic [1:0]              state,
    output logic                    done
);

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_load;
    logic                    w_hit;

    logic [c_SCORE_BITS-1:0] r_last_combo;
    logic [c_SCORE_BITS-1:0] r_now_cnt;
    logic [c_SCORE_BITS-1:0] r_last_base;
    logic [SCORE_W-1:0]      r_total_score;
    logic [c_SCORE_BITS-1:0] r_max_combo;
    logic [c_SCORE_BITS-1:0] r_miss_count;
    logic [6:0]              r_health;
    logic [c_SCORE_BITS-1:0] r_total_note;
    logic [1:0]              r_mod;

    logic [c_SCORE_BITS-1:0] w_now_upd;
    logic [c_SCORE_BITS-1:0] w_last_base_upd;
    logic [SCORE_W-1:0]      w_total_upd;
    logic [c_SCORE_BITS:0]   w_note_sum;
    logic [6:0]              w_health_upd;
    logic                    w_miss;

    // ---------------------------------------------------------------------
    // Per-note updates, evaluated from the values left by the previous note
    // ---------------------------------------------------------------------
    assign w_miss    = (base_score == '0);
    assign w_now_upd = r_now_cnt + 1'b1;

    // Base and bonus are summed at full precision before entering the total.
    assign w_note_sum = {1'b0, base_score} + {1'b0, bonus_score};

    sat_add #(.W(c_SCORE_BITS)) u_sat_base (
        .i_a   (r_last_base),
        .i_b   (base_score),
        .o_sum (w_last_base_upd)
    );

    sat_add #(.W(SCORE_W)) u_sat_total (
        .i_a   (r_total_score),
        .i_b   (SCORE_W'(w_note_sum)),
        .o_sum (w_total_upd)
    );

    // Health floors at 0 on a miss and is clamped to HP_MAX on a gain.
    always_comb begin
        w_health_upd = r_health;
        if (w_miss) begin
            w_health_upd = (r_health > 7'(HP_MISS)) ? (r_health - 7'(HP_MISS)) : 7'd0;
        end else begin
            w_health_upd = (({1'b0, r_health} + 8'(HP_GAIN)) >= 8'(HP_MAX))
                         ? 7'(HP_MAX) : (r_health + 7'(HP_GAIN));
        end
    end

    // ---------------------------------------------------------------------
    // FSM: abort > start > hit_valid
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_hit        = 1'b0;
        if (abort) begin
            w_next_state = c_ST_IDLE;
        end else if (start && (r_state != c_ST_PLAY)) begin
            w_load = 1'b1;
            // An empty song finishes immediately.
            if (total_note == '0) begin
                w_next_state = c_ST_DONE;
                w_done_nxt   = 1'b1;
            end else begin
                w_next_state = c_ST_PLAY;
            end
        end else if (hit_valid && (r_state == c_ST_PLAY)) begin
            w_hit = 1'b1;
            // A fatal miss on the last note still counts as a failure.
            if ((w_health_upd == 7'd0) && (r_mod != c_MOD_NOFAIL)) begin
                w_next_state = c_ST_FAILED;
                w_done_nxt   = 1'b1;
            end else if (w_now_upd == r_total_note) begin
                w_next_state = c_ST_DONE;
                w_done_nxt   = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers; abort leaves them holding until the next start
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_combo  <= '0;
            r_now_cnt     <= '0;
            r_last_base   <= '0;
            r_total_score <= '0;
            r_max_combo   <= '0;
            r_miss_count  <= '0;
            r_health      <= 7'(HP_START);
            r_total_note  <= '0;
            r_mod         <= 2'b00;
        end else if (w_load) begin
            r_last_combo  <= '0;
            r_now_cnt     <= '0;
            r_last_base   <= '0;
            r_total_score <= '0;
            r_max_combo   <= '0;
            r_miss_count  <= '0;
            r_health      <= 7'(HP_START);
            r_total_note  <= total_note;
            r_mod         <= mod;
        end else if (w_hit) begin
            r_now_cnt     <= w_now_upd;
            r_last_combo  <= combo;
            r_last_base   <= w_last_base_upd;
            r_total_score <= w_total_upd;
            r_health      <= w_health_upd;
            if (combo > r_max_combo) begin
                r_max_combo <= combo;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign last_combo      = r_last_combo;
    assign now_cnt         = r_now_cnt;
    assign last_base_score = r_last_base;
    assign total_score     = r_total_score;
    assign max_combo       = r_max_combo;
    assign miss_count      = r_miss_count;
    assign health          = r_health;
    assign state           = r_state;
    assign done            = r_done;

endmodule : score_keeper
`default_nettype wire
